fpga_test_sequencer: RTL

- Runs NTests generated program modules back to back, each one in isolation.
- For the selected program it holds that program's reset, releases it, and watches its finished/success outputs.
- Applies a watchdog timeout per program and records the results.
- Sits above the program modules in the board top level and drives the board-level pass/fail status.

---
 rtl/fpga_test_sequencer_if.sv | 36 +++
 rtl/fpga_test_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fpga_test_sequencer_if.sv
// Signal bundle between the test sequencer and the program modules / board status logic.
// The slave side is the sequencer; the master side drives start and the per-program flags.
interface fpga_test_sequencer_if #(
  parameter int NTests     = 4,
  parameter int CountWidth = 32
);
  localparam int CurW  = (NTests > 1) ? $clog2(NTests) : 1;
  localparam int PassW = $clog2(NTests + 1);

  // start is a one-cycle pulse, only acted on when busy is low; there is no ready/ack.
  logic                  start;
  logic [NTests-1:0]     testReset;
  logic [NTests-1:0]     testFinished;
  logic [NTests-1:0]     testSuccess;
  logic                  busy;
  logic                  done;
  logic [NTests-1:0]     passMask;
  logic [NTests-1:0]     timeoutMask;
  logic [PassW-1:0]      passCount;
  logic [CurW-1:0]       currentTest;
  logic [CountWidth-1:0] totalCycles;
  logic                  allPassed;
  logic [2:0]            debugState;

  modport master (
    output start, testFinished, testSuccess,
    input  testReset, busy, done, passMask, timeoutMask, passCount,
           currentTest, totalCycles, allPassed, debugState
  );

  modport slave (
    input  start, testFinished, testSuccess,
    output testReset, busy, done, passMask, timeoutMask, passCount,
           currentTest, totalCycles, allPassed, debugState
  );
endinterface

// File: rtl/fpga_test_sequencer.sv
// Runs each program module in turn: hold its reset, release it, wait for finished or the
// watchdog, then record pass/timeout. All outputs come straight from registers.
module fpga_test_sequencer #(
  parameter int NTests      = 4,
  parameter int ResetCycles = 2,
  parameter int MaxCycles   = 1000,
  parameter int CountWidth  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  fpga_test_sequencer_if.slave   bus
);
  localparam int CurW  = (NTests > 1) ? $clog2(NTests) : 1;
  localparam int PassW = $clog2(NTests + 1);
  localparam int HoldW = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HOLD   = 3'd1,
    S_RUN    = 3'd2,
    S_RECORD = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [HoldW-1:0]      hold_q, hold_d;
  logic [CountWidth-1:0] cyc_q, cyc_d, cyc_inc, total_inc;
  logic                  pass_q, pass_d, to_q, to_d;
  logic [NTests-1:0]     test_reset_q, test_reset_d;
  logic                  busy_q, busy_d, done_q, done_d, all_q, all_d;
  logic [NTests-1:0]     pass_mask_q, pass_mask_d, to_mask_q, to_mask_d;
  logic [PassW-1:0]      pass_cnt_q, pass_cnt_d;
  logic [CurW-1:0]       cur_q, cur_d;
  logic [CountWidth-1:0] total_q, total_d;

  // Both counters stick at all ones instead of wrapping.
  assign cyc_inc   = (&cyc_q)   ? cyc_q   : cyc_q + CountWidth'(1);
  assign total_inc = (&total_q) ? total_q : total_q + CountWidth'(1);

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    cyc_d        = cyc_q;
    pass_d       = pass_q;
    to_d         = to_q;
    test_reset_d = test_reset_q;
    busy_d       = busy_q;
    done_d       = done_q;
    all_d        = all_q;
    pass_mask_d  = pass_mask_q;
    to_mask_d    = to_mask_q;
    pass_cnt_d   = pass_cnt_q;
    cur_d        = cur_q;
    total_d      = total_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        test_reset_d = '1;
        if (bus.start) begin
          pass_mask_d = '0;
          to_mask_d   = '0;
          pass_cnt_d  = '0;
          total_d     = '0;
          cur_d       = '0;
          hold_d      = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          all_d       = 1'b0;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_q == HoldW'(ResetCycles - 1)) begin
          cyc_d               = '0;
          test_reset_d        = '1;
          test_reset_d[cur_q] = 1'b0;
          state_d             = S_RUN;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      S_RUN: begin
        cyc_d   = cyc_inc;
        total_d = total_inc;
        // finished takes priority over a watchdog expiry in the same cycle
        if (bus.testFinished[cur_q]) begin
          pass_d       = bus.testSuccess[cur_q];
          to_d         = 1'b0;
          test_reset_d = '1;
          state_d      = S_RECORD;
        end else if (cyc_inc >= CountWidth'(MaxCycles)) begin
          pass_d       = 1'b0;
          to_d         = 1'b1;
          test_reset_d = '1;
          state_d      = S_RECORD;
        end
      end
      S_RECORD: begin
        pass_mask_d[cur_q] = pass_q;
        to_mask_d[cur_q]   = to_q;
        pass_cnt_d         = pass_cnt_q + PassW'(pass_q);
        if (cur_q == CurW'(NTests - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          all_d   = (pass_cnt_d == PassW'(NTests));
          state_d = S_DONE;
        end else begin
          cur_d   = cur_q + CurW'(1);
          hold_d  = '0;
          state_d = S_HOLD;
        end
      end
      default: begin
        test_reset_d = '1;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      cyc_q        <= '0;
      pass_q       <= 1'b0;
      to_q         <= 1'b0;
      test_reset_q <= '1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      all_q        <= 1'b0;
      pass_mask_q  <= '0;
      to_mask_q    <= '0;
      pass_cnt_q   <= '0;
      cur_q        <= '0;
      total_q      <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cyc_q        <= cyc_d;
      pass_q       <= pass_d;
      to_q         <= to_d;
      test_reset_q <= test_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      all_q        <= all_d;
      pass_mask_q  <= pass_mask_d;
      to_mask_q    <= to_mask_d;
      pass_cnt_q   <= pass_cnt_d;
      cur_q        <= cur_d;
      total_q      <= total_d;
    end
  end

  assign bus.testReset   = test_reset_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.passMask    = pass_mask_q;
  assign bus.timeoutMask = to_mask_q;
  assign bus.passCount   = pass_cnt_q;
  assign bus.currentTest = cur_q;
  assign bus.totalCycles = total_q;
  assign bus.allPassed   = all_q;
  assign bus.debugState  = state_q;
endmodule
